trigger_capture: RTL and testbench
==================================

Name: trigger_capture

Overview:
- Sys_clk-domain consumer of single-cycle trigger pulses, such as counter-equals-value flags.
- Latches each pulse into a sticky pending bit and holds it until the host-side read path reads and clears it.
- Counts pulses lost because their bit was already pending.
- Drives an interrupt with programmable holdoff so bursts of events are coalesced into one host service.

Parameters:
WIDTH, 32, number of trigger bits captured
CNT_W, 8, width of the saturating missed-event counter
HOLDOFF, 16, sys_clk cycles irq stays deasserted after a read (0 = no holdoff)

Ports:
sys_clk  input  1  single clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
trig_in  input  WIDTH  trigger pulses, each bit sampled every cycle
trig_mask  input  WIDTH  1 = bit enabled for capture
rd_req  input  1  one-cycle read-and-clear strobe, synchronous to sys_clk
rd_ack  output  1  one-cycle pulse; rd_data and rd_miss are valid
rd_data  output  WIDTH  snapshot of pending at the accepted read
rd_miss  output  CNT_W  snapshot of the missed-event count at the accepted read
pending  output  WIDTH  live sticky capture register
irq  output  1  registered interrupt request

Behaviour:
- Reset (async assert, sync release): pending=0, miss_cnt=0, rd_data=0, rd_miss=0, rd_ack=0, irq=0, FSM=IDLE, holdoff counter=0.
- set = trig_in & trig_mask. clr = pending when rd_req=1, else 0.
- pending <= (pending & ~clr) | set.
  - A pulse in the same cycle as a read is never lost; it appears in pending after the read.
- Collision: (set & pending & ~clr) != 0 in a cycle.
  - miss_cnt increments by 1 per collision cycle, not per bit.
  - miss_cnt saturates at all-ones.
- Read cycle (rd_req=1):
  - rd_data <= pending and rd_miss <= miss_cnt, both registered.
  - miss_cnt <= 0. No collision is possible on a read cycle because clr = pending.
  - rd_ack = 1 in the following cycle only. Latency rd_req -> rd_ack is 1 cycle.
- Back-to-back reads: every rd_req is accepted, with no busy state.
  - A second read returns only bits set since the first read.
- rd_data and rd_miss hold their values until the next accepted read.
- trig_mask changes affect only future pulses; already-pending bits are not cleared.
- Interrupt FSM (irq is 1 only in ASSERT; irq is registered):
  - IDLE -> ASSERT when pending != 0. irq rises 1 cycle after pending becomes nonzero.
  - ASSERT -> HOLD on rd_req; the counter loads HOLDOFF.
    - If HOLDOFF=0, go to IDLE instead.
  - HOLD: the counter decrements each cycle.
    - At zero -> ASSERT if pending != 0, else IDLE.
    - HOLD therefore lasts exactly HOLDOFF cycles.
    - rd_req in HOLD reloads the counter (holdoff restarts).
  - rd_req in IDLE: accepted normally, may return 0; state stays IDLE.
  - Reset in any state returns to IDLE immediately, and irq drops asynchronously.
- Width rules:
  - miss_cnt is CNT_W bits unsigned.
  - The holdoff counter is sized to clog2(HOLDOFF+1) bits, minimum 1.

Test Plan:
- Reset sequence: hold reset_n=0 mid-burst -> all outputs 0 immediately. After release, trig_in=0x1 for 1 cycle -> pending=0x1 next cycle, irq=1 one cycle later.
- Read clear: pending=0x3, pulse rd_req -> rd_ack 1 cycle later, rd_data=0x3, pending=0, irq low for exactly 16 cycles (HOLDOFF=16), then stays 0 since pending=0.
- Same-cycle set and clear: pending=0x1, trig_in=0x1 with rd_req -> rd_data=0x1, pending=0x1 afterwards, miss_cnt unchanged (0).
- Collisions: pending=0x1, trig_in=0x1 on 3 cycles and 0x3 on 1 cycle -> miss_cnt=4, pending=0x3. Drive 300 collision cycles with CNT_W=8 -> rd_miss=0xFF, then miss_cnt=0 after the read.
- Mask: trig_mask=0xFFFFFFFE, trig_in=0x1 -> pending stays 0, irq stays 0. trig_in=0x2 -> pending=0x2.
- Holdoff coalescing: after a read, pulse trig_in=0x4 at holdoff cycle 5 -> irq stays 0 until the counter expires, then irq=1 with pending=0x4. A second rd_req during HOLD restarts the full 16-cycle holdoff.

Source files
------------

// File: rtl/trigger_capture.sv
// Sticky capture of single-cycle trigger pulses with read-and-clear, a saturating
// missed-event counter and an interrupt whose re-assertion is held off after each read.
module trigger_capture #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 16
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] trig_in,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] rd_miss,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  localparam int              HO_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);
  localparam logic [HO_W-1:0] HO_ONE  = HO_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_rd_data;
  logic [CNT_W-1:0] r_rd_miss;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             r_rd_ack;
  logic             r_irq;
  state_t           r_state;
  logic [HO_W-1:0]  r_ho_cnt;

  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_pending_next;
  logic             w_collision;
  logic             w_miss_sat;
  state_t           w_state_next;
  logic [HO_W-1:0]  w_ho_next;

  // A read clears exactly what it snapshots, so a same-cycle pulse survives it.
  assign w_set          = trig_in & trig_mask;
  assign w_clr          = rd_req ? r_pending : '0;
  assign w_pending_next = (r_pending & ~w_clr) | w_set;
  assign w_collision    = |(w_set & r_pending & ~w_clr);
  assign w_miss_sat     = &r_miss_cnt;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_miss_cnt <= '0;
      r_rd_data  <= '0;
      r_rd_miss  <= '0;
      r_rd_ack   <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_rd_ack  <= rd_req;
      if (rd_req) begin
        r_rd_data  <= r_pending;
        r_rd_miss  <= r_miss_cnt;
        r_miss_cnt <= '0;
      end else if (w_collision && !w_miss_sat) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  // The holdoff window ends on the cycle the counter would reach zero,
  // so HOLD spans exactly HOLDOFF cycles.
  always_comb begin
    w_state_next = r_state;
    w_ho_next    = r_ho_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!rd_req && (|r_pending)) begin
          w_state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (rd_req) begin
          if (HOLDOFF == 0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_HOLD;
            w_ho_next    = HO_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (rd_req) begin
          w_ho_next = HO_LOAD;
        end else if (r_ho_cnt <= HO_ONE) begin
          w_ho_next    = '0;
          w_state_next = (|r_pending) ? ST_ASSERT : ST_IDLE;
        end else begin
          w_ho_next = r_ho_cnt - HO_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_ho_next    = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ho_cnt <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ho_cnt <= w_ho_next;
      r_irq    <= (w_state_next == ST_ASSERT);
    end
  end

  assign rd_ack  = r_rd_ack;
  assign rd_data = r_rd_data;
  assign rd_miss = r_rd_miss;
  assign pending = r_pending;
  assign irq     = r_irq;

endmodule

// File: tb/tb_trigger_capture.sv
// Scenario bench for trigger_capture: expected read results are queued when a read
// is issued and compared when rd_ack appears one cycle later.
`timescale 1ns/1ps
module tb_trigger_capture;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  miss;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic [31:0] trig_in;
  logic [31:0] trig_mask;
  logic        rd_req;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [7:0]  rd_miss;
  logic [31:0] pending;
  logic        irq;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];
  exp_t exp_e;
  int   hi_cnt;

  trigger_capture #(.WIDTH(32), .CNT_W(8), .HOLDOFF(16)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .trig_in  (trig_in),
    .trig_mask(trig_mask),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .rd_miss  (rd_miss),
    .pending  (pending),
    .irq      (irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue_read(input logic [31:0] d, input logic [7:0] m);
    exp_t e;
    e.data = d;
    e.miss = m;
    sb_q.push_back(e);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trig_in = '0; trig_mask = '1; rd_req = 1'b0;
    step(); step();
    tests_run++;
    if ({rd_ack, rd_data, rd_miss, pending, irq} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: ack=%b data=%h miss=%h pend=%h irq=%b, required all 0", rd_ack, rd_data, rd_miss, pending, irq);
    end
    reset_n = 1'b1; trig_in = 32'h5;
    step();
    tests_run++;
    if (pending !== 32'h5) begin tests_failed++; $display("FAIL reset_first_pend: got %h, required 00000005", pending); end
    step();
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL reset_first_irq: got %b, required 1", irq); end
    issue_read(32'h5, 8'h1);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL reset_read: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    repeat (16) step();
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL reset_burst_irq: got %b, required 1", irq); end
    reset_n = 1'b0;
    #2;
    tests_run++;
    if ({rd_ack, rd_data, rd_miss, pending, irq} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: ack=%b data=%h miss=%h pend=%h irq=%b, required all 0", rd_ack, rd_data, rd_miss, pending, irq);
    end
    step();
    tests_run++;
    if (pending !== 32'h0 || irq !== 1'b0) begin tests_failed++; $display("FAIL reset_held: pend=%h irq=%b, required 0 0", pending, irq); end
    trig_in = '0;
    step();
    reset_n = 1'b1; trig_in = 32'h1;
    step();
    trig_in = '0;
    tests_run++;
    if (pending !== 32'h1 || irq !== 1'b0) begin tests_failed++; $display("FAIL release_pend: pend=%h irq=%b, required 00000001 0", pending, irq); end
    step();
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL release_irq: got %b, required 1", irq); end
  endtask

  task automatic test_read_clear();
    trig_in = 32'h2;
    step();
    trig_in = '0;
    tests_run++;
    if (pending !== 32'h3) begin tests_failed++; $display("FAIL rc_pend: got %h, required 00000003", pending); end
    issue_read(32'h3, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL rc_read: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    tests_run++;
    if (pending !== 32'h0 || irq !== 1'b0) begin tests_failed++; $display("FAIL rc_cleared: pend=%h irq=%b, required 0 0", pending, irq); end
    step();
    tests_run++;
    if (rd_ack !== 1'b0 || rd_data !== 32'h3) begin tests_failed++; $display("FAIL rc_hold: ack=%b data=%h, required 0 00000003", rd_ack, rd_data); end
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (irq !== 1'b0) hi_cnt++; end
    tests_run++;
    if (hi_cnt != 0) begin tests_failed++; $display("FAIL rc_irq_quiet: irq high %0d cycles, required 0", hi_cnt); end
  endtask

  task automatic test_same_cycle();
    trig_in = 32'h1;
    step();
    tests_run++;
    if (pending !== 32'h1) begin tests_failed++; $display("FAIL sc_pend: got %h, required 00000001", pending); end
    issue_read(32'h1, 8'h0);
    trig_in = '0;
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL sc_read: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    tests_run++;
    if (pending !== 32'h1) begin tests_failed++; $display("FAIL sc_survive: got %h, required 00000001", pending); end
    issue_read(32'h1, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL sc_read2: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    repeat (20) step();
  endtask

  task automatic test_collisions();
    trig_in = 32'h1;
    step(); step(); step(); step();
    trig_in = 32'h3;
    step();
    trig_in = '0;
    tests_run++;
    if (pending !== 32'h3) begin tests_failed++; $display("FAIL col_pend: got %h, required 00000003", pending); end
    issue_read(32'h3, 8'd4);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL col_count: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    trig_in = 32'h1;
    step();
    repeat (300) step();
    trig_in = '0;
    issue_read(32'h1, 8'hFF);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL col_saturate: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    issue_read(32'h0, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL col_cleared: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    repeat (20) step();
  endtask

  task automatic test_back_to_back();
    trig_in = 32'h40;
    step();
    trig_in = 32'h80;
    issue_read(32'h40, 8'h0);
    trig_in = '0;
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL b2b_first: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    issue_read(32'h80, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL b2b_second: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    issue_read(32'h0, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL b2b_third: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    repeat (20) step();
  endtask

  task automatic test_mask();
    trig_mask = 32'hFFFF_FFFE;
    trig_in   = 32'h1;
    step();
    trig_in = '0;
    tests_run++;
    if (pending !== 32'h0) begin tests_failed++; $display("FAIL mask_block: got %h, required 00000000", pending); end
    step();
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL mask_irq: got %b, required 0", irq); end
    trig_in = 32'h2;
    step();
    trig_in = '0;
    tests_run++;
    if (pending !== 32'h2) begin tests_failed++; $display("FAIL mask_pass: got %h, required 00000002", pending); end
    trig_mask = '0;
    step();
    tests_run++;
    if (pending !== 32'h2) begin tests_failed++; $display("FAIL mask_keep: got %h, required 00000002", pending); end
    trig_mask = '1;
    issue_read(32'h2, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL mask_read: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    repeat (20) step();
    issue_read(32'h0, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_read: ack=%b data=%h miss=%h irq=%b, required ack=1 data=%h miss=%h irq=0", rd_ack, rd_data, rd_miss, irq, exp_e.data, exp_e.miss);
    end
  endtask

  task automatic test_holdoff();
    trig_in = 32'h1;
    step();
    trig_in = '0;
    step();
    issue_read(32'h1, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL ho_read: ack=%b data=%h miss=%h irq=%b, required ack=1 data=%h miss=%h irq=0", rd_ack, rd_data, rd_miss, irq, exp_e.data, exp_e.miss);
    end
    hi_cnt = 0;
    for (int k = 2; k <= 16; k++) begin
      if (k == 5) trig_in = 32'h4;
      step();
      trig_in = '0;
      if (irq !== 1'b0) hi_cnt++;
    end
    tests_run++;
    if (hi_cnt != 0) begin tests_failed++; $display("FAIL ho_window: irq high %0d cycles, required 0", hi_cnt); end
    step();
    tests_run++;
    if (irq !== 1'b1 || pending !== 32'h4) begin tests_failed++; $display("FAIL ho_expire: irq=%b pend=%h, required 1 00000004", irq, pending); end
    issue_read(32'h4, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL ho_read2: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    for (int k = 2; k <= 8; k++) begin
      if (k == 3) trig_in = 32'h8;
      step();
      trig_in = '0;
    end
    issue_read(32'h8, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL ho_reload_read: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
    hi_cnt = 0;
    for (int j = 2; j <= 16; j++) begin
      if (j == 2) trig_in = 32'h10;
      step();
      trig_in = '0;
      if (irq !== 1'b0) hi_cnt++;
    end
    tests_run++;
    if (hi_cnt != 0) begin tests_failed++; $display("FAIL ho_restart: irq high %0d cycles, required 0", hi_cnt); end
    step();
    tests_run++;
    if (irq !== 1'b1 || pending !== 32'h10) begin tests_failed++; $display("FAIL ho_restart_end: irq=%b pend=%h, required 1 00000010", irq, pending); end
    issue_read(32'h10, 8'h0);
    tests_run++;
    exp_e = sb_q.pop_front();
    if (rd_ack !== 1'b1 || rd_data !== exp_e.data || rd_miss !== exp_e.miss) begin
      tests_failed++;
      $display("FAIL ho_final_read: ack=%b data=%h miss=%h, required ack=1 data=%h miss=%h", rd_ack, rd_data, rd_miss, exp_e.data, exp_e.miss);
    end
  endtask

  initial begin
    test_reset();
    test_read_clear();
    test_same_cycle();
    test_collisions();
    test_back_to_back();
    test_mask();
    test_holdoff();
    tests_run++;
    if (sb_q.size() != 0) begin tests_failed++; $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
